// File: rtl/mib_rx_pkg.sv
// Shared constants for the MIB receive path: FSM state encoding for the RE
// stream reader and the DMRS grouping used when skipping PBCH DMRS REs.
package mib_rx_pkg;

  // One DMRS RE in every group of four REs (offset selected by nu_shift).
  localparam int unsigned RE_PER_DMRS_GROUP = 4;
  localparam int unsigned DMRS_SEL_W        = $clog2(RE_PER_DMRS_GROUP);

  // Reader FSM encoding.
  localparam int unsigned ST_W     = 2;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_READ  = 2'd1;
  localparam logic [1:0]  ST_DRAIN = 2'd2;

  // Output buffer occupancy counter width (holds 0..2).
  localparam int unsigned FIFO_CNT_W = 2;

  // True when the RE index (mod 4) lands on the DMRS offset.
  function automatic logic is_dmrs_re(input logic [DMRS_SEL_W-1:0] idx_lo,
                                      input logic [1:0]            nu);
    return idx_lo == nu;
  endfunction

endpackage

// File: rtl/re_out_fifo.sv
// Two-entry output FIFO with valid/ready on the read side.
// Ports: clk, rst_n (async active-low), i_push/i_data/i_last (write, never
// pushed when full), o_valid/o_data/o_last/i_ready (stream), o_cnt (occupancy).
// Entry 0 is always the head, so o_data/o_last come straight from flops.
module re_out_fifo
  import mib_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_last,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_last,
  input  logic                  i_ready,
  output logic [FIFO_CNT_W-1:0] o_cnt
);

  logic [WIDTH-1:0]      r_d0, r_d1, w_d0_nxt, w_d1_nxt;
  logic                  r_l0, r_l1, w_l0_nxt, w_l1_nxt;
  logic [FIFO_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                  r_valid;
  logic                  w_pop;

  assign w_pop   = r_valid & i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_d0;
  assign o_last  = r_l0;
  assign o_cnt   = r_cnt;

  // Next-entry selection for push/pop combinations.
  always_comb begin
    w_d0_nxt  = r_d0;
    w_l0_nxt  = r_l0;
    w_d1_nxt  = r_d1;
    w_l1_nxt  = r_l1;
    w_cnt_nxt = r_cnt;
    unique case ({i_push, w_pop})
      2'b10: begin
        if (r_cnt == 2'd0) begin
          w_d0_nxt = i_data;
          w_l0_nxt = i_last;
        end else begin
          w_d1_nxt = i_data;
          w_l1_nxt = i_last;
        end
        if (r_cnt != 2'd2) w_cnt_nxt = r_cnt + 2'd1;
      end
      2'b01: begin
        // Drop the head; a stale last flag must not linger on an empty buffer.
        w_d0_nxt  = r_d1;
        w_l0_nxt  = (r_cnt == 2'd2) & r_l1;
        w_cnt_nxt = r_cnt - 2'd1;
      end
      2'b11: begin
        if (r_cnt == 2'd1) begin
          w_d0_nxt = i_data;
          w_l0_nxt = i_last;
        end else begin
          w_d0_nxt = r_d1;
          w_l0_nxt = r_l1;
          w_d1_nxt = i_data;
          w_l1_nxt = i_last;
        end
      end
      default: ;
    endcase
  end

  // Storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d0    <= '0;
      r_d1    <= '0;
      r_l0    <= 1'b0;
      r_l1    <= 1'b0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_d0    <= w_d0_nxt;
      r_d1    <= w_d1_nxt;
      r_l0    <= w_l0_nxt;
      r_l1    <= w_l1_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != 2'd0);
    end
  end

endmodule

// File: rtl/re_stream_reader.sv
// RE stream reader: scans length REs from a circular RAM starting at
// base_addr and streams the samples out over valid/ready.
// Ports: clk, rst (async active-low), start/base_addr/length/nu_shift (burst
// request, sampled in IDLE), ram_addr/ram_wre/ram_dout (1-cycle-latency RAM
// read port), m_data/m_valid/m_ready/m_last (stream), busy, done.
// Build option: PBCH_DMRS_SKIP_EN drops every RE whose index mod 4 equals
// nu_shift; without it every RE is emitted and nu_shift is ignored.
// ram_addr is combinational so a read can be issued in the same cycle the
// consumer frees a buffer slot, sustaining one sample per cycle.
module re_stream_reader
  import mib_rx_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = 32,
  parameter int unsigned RAM_DEPTH  = 240,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [1:0]            nu_shift,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wre,
  input  logic [RAM_WIDTH-1:0]  ram_dout,
  output logic [RAM_WIDTH-1:0]  m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned SUM_W = ADDR_WIDTH + 1;

  logic [ST_W-1:0]       r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base, r_len, r_idx;
  logic                  r_inflight, r_infl_last, r_hold, r_busy, r_done;
  logic                  w_issue, w_adv, w_done_nxt, w_pop, w_room;
  logic                  w_skip, w_last_idx, w_last_emit, w_fifo_drains;
  logic [SUM_W-1:0]      w_sum;
  logic [ADDR_WIDTH-1:0] w_addr, w_len_m1;
  logic [FIFO_CNT_W-1:0] w_fifo_cnt, w_occ;

  // Circular address: base + index, folded back once past the last RAM word.
  assign w_sum  = {1'b0, r_base} + {1'b0, r_idx};
  assign w_addr = (w_sum >= SUM_W'(RAM_DEPTH)) ? ADDR_WIDTH'(w_sum - SUM_W'(RAM_DEPTH))
                                               : ADDR_WIDTH'(w_sum);

  assign w_len_m1   = r_len - ADDR_WIDTH'(1);
  assign w_last_idx = (r_idx == w_len_m1);

`ifdef PBCH_DMRS_SKIP_EN
  logic [1:0] r_nu;
  assign w_skip      = is_dmrs_re(r_idx[DMRS_SEL_W-1:0], r_nu);
  // Last emitted RE is the final index, or the one before it when the final
  // index is itself a DMRS RE.
  assign w_last_emit = w_last_idx |
                       ((r_idx == r_len - ADDR_WIDTH'(2)) &
                        is_dmrs_re(w_len_m1[DMRS_SEL_W-1:0], r_nu));
`else
  logic w_unused_nu;
  assign w_unused_nu = ^nu_shift;
  assign w_skip      = 1'b0;
  assign w_last_emit = w_last_idx;
`endif

  // Buffer slots left after this cycle's pop, counting the read in flight.
  assign w_pop         = m_valid & m_ready;
  assign w_occ         = w_fifo_cnt - {1'b0, w_pop} + {1'b0, r_inflight};
  assign w_room        = (w_occ < 2'd2);
  assign w_fifo_drains = (w_fifo_cnt == 2'd0) | ((w_fifo_cnt == 2'd1) & w_pop);

  assign ram_addr = w_issue ? w_addr : '0;
  assign ram_wre  = 1'b0;
  assign busy     = r_busy;
  assign done     = r_done;

  // Next-state and read-issue decode.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_adv       = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (length == '0) ? ST_DRAIN : ST_READ;
      end
      ST_READ: begin
        // Skipped REs advance the scan without needing a buffer slot.
        w_adv   = w_skip | w_room;
        w_issue = ~w_skip & w_room;
        if (w_adv && w_last_idx) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_hold && !r_inflight && w_fifo_drains) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, burst context and read pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
      r_hold      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef PBCH_DMRS_SKIP_EN
      r_nu        <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE) | w_done_nxt;
      r_inflight  <= w_issue;
      r_infl_last <= w_issue & w_last_emit;
      if (r_state == ST_IDLE && start) begin
        r_base <= base_addr;
        r_len  <= length;
        r_idx  <= '0;
        // A zero-length burst waits one cycle in DRAIN, matching the
        // start-to-output spacing of the read pipeline.
        r_hold <= (length == '0);
`ifdef PBCH_DMRS_SKIP_EN
        r_nu   <= nu_shift;
`endif
      end else begin
        r_hold <= 1'b0;
        if (w_adv) r_idx <= r_idx + ADDR_WIDTH'(1);
      end
    end
  end

  // Read data lands in the buffer one cycle after the address is sampled.
  re_out_fifo #(.WIDTH(RAM_WIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (r_inflight),
    .i_data  (ram_dout),
    .i_last  (r_infl_last),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_last  (m_last),
    .i_ready (m_ready),
    .o_cnt   (w_fifo_cnt)
  );

endmodule
